// File: rtl/fpu_ss_issue_ctrl.sv
`default_nettype none
// ============================================================================
// fpu_ss_issue_ctrl : in-order issue/retire controller for the FPU subsystem.
// Optional perf counters: define FPU_SS_ISSUE_CTRL_PERF_EN.   Rev 1.0
// ============================================================================

package acc_pkg;
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_req_type_e;
endpackage

module fpu_ss_issue_ctrl #(
    parameter int unsigned MAX_INFLIGHT        = 4,
    parameter int unsigned MEM_MAX_OUTSTANDING = 2,
    parameter int unsigned INT_WB_DELAY        = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              pop_valid_i,
    output logic                              pop_ready_o,
    input  logic                              use_fpu_i,
    input  logic                              rd_is_fp_i,
    input  logic                              csr_instr_i,
    input  logic                              is_load_i,
    input  logic                              is_store_i,
    output logic                              fpu_in_valid_o,
    input  logic                              fpu_in_ready_i,
    input  logic                              fpu_out_valid_i,
    output logic                              fpu_out_ready_o,
    output logic                              fpr_we_o,
    output logic                              c_p_valid_o,
    input  logic                              c_p_ready_i,
    output logic                              cmem_q_valid_o,
    input  logic                              cmem_q_ready_i,
    output acc_pkg::mem_req_type_e            cmem_q_req_type_o,
    output logic                              cmem_q_mode_o,
    output logic                              cmem_q_spec_o,
    output logic                              cmem_q_endoftransaction_o,
    input  logic                              cmem_p_valid_i,
    output logic                              cmem_p_ready_o,
    output logic [$clog2(MAX_INFLIGHT):0]     inflight_cnt_o,
`ifdef FPU_SS_ISSUE_CTRL_PERF_EN
    output logic [31:0]                       perf_issued_o,
    output logic [31:0]                       perf_retired_o,
    output logic [31:0]                       perf_stall_o,
`endif
    output logic                              idle_o
);

    localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] MEM_MAX  = CNT_W'(MEM_MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [2:0]       WAIT_TGT = 3'(INT_WB_DELAY);

    typedef enum logic [2:0] {
        CLS_INT = 3'd0,
        CLS_FPF = 3'd1,
        CLS_FPI = 3'd2,
        CLS_LD  = 3'd3,
        CLS_ST  = 3'd4
    } cls_e;

    cls_e               cls_q [MAX_INFLIGHT];
    cls_e               issue_cls;
    cls_e               head_cls;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   mem_cnt;
    logic [2:0]         wait_cnt;
    logic               room;
    logic               mem_room;
    logic               head_valid;
    logic               do_pop;
    logic               do_retire;
    logic               mem_req_hs;
    logic               mem_rsp_hs;

    assign room       = (occ < MAX_CNT);
    assign mem_room   = (mem_cnt < MEM_MAX);
    assign head_valid = (occ != '0);
    assign head_cls   = cls_q[rd_ptr];

    always_comb begin
        issue_cls = CLS_INT;
        if (csr_instr_i)     issue_cls = CLS_INT;
        else if (is_load_i)  issue_cls = CLS_LD;
        else if (is_store_i) issue_cls = CLS_ST;
        else if (use_fpu_i)  issue_cls = rd_is_fp_i ? CLS_FPF : CLS_FPI;
    end

    // Issue side; every handshake output is forced low while reset is held.
    always_comb begin
        fpu_in_valid_o = 1'b0;
        cmem_q_valid_o = 1'b0;
        do_pop         = 1'b0;
        if (!rst_i && pop_valid_i && room) begin
            case (issue_cls)
                CLS_FPF, CLS_FPI: begin
                    fpu_in_valid_o = 1'b1;
                    do_pop         = fpu_in_ready_i;
                end
                CLS_LD, CLS_ST: begin
                    cmem_q_valid_o = mem_room;
                    do_pop         = mem_room && cmem_q_ready_i;
                end
                default: do_pop = 1'b1;
            endcase
        end
    end

    assign pop_ready_o               = do_pop;
    assign cmem_q_req_type_o         = (!rst_i && pop_valid_i && issue_cls == CLS_ST)
                                       ? acc_pkg::WRITE : acc_pkg::READ;
    assign cmem_q_mode_o             = 1'b0;
    assign cmem_q_spec_o             = 1'b0;
    assign cmem_q_endoftransaction_o = cmem_q_valid_o;

    // Retire side: only the head entry may consume a result, others stall.
    always_comb begin
        fpu_out_ready_o = 1'b0;
        fpr_we_o        = 1'b0;
        c_p_valid_o     = 1'b0;
        cmem_p_ready_o  = 1'b0;
        do_retire       = 1'b0;
        if (!rst_i && head_valid) begin
            case (head_cls)
                CLS_FPF: begin
                    fpu_out_ready_o = 1'b1;
                    fpr_we_o        = fpu_out_valid_i;
                    do_retire       = fpu_out_valid_i;
                end
                CLS_FPI: begin
                    c_p_valid_o     = fpu_out_valid_i;
                    fpu_out_ready_o = c_p_ready_i;
                    do_retire       = fpu_out_valid_i && c_p_ready_i;
                end
                CLS_LD: begin
                    cmem_p_ready_o  = 1'b1;
                    fpr_we_o        = cmem_p_valid_i;
                    do_retire       = cmem_p_valid_i;
                end
                CLS_ST: begin
                    cmem_p_ready_o  = 1'b1;
                    do_retire       = cmem_p_valid_i;
                end
                default: begin
                    c_p_valid_o     = (wait_cnt == WAIT_TGT);
                    do_retire       = (wait_cnt == WAIT_TGT) && c_p_ready_i;
                end
            endcase
        end
    end

    assign mem_req_hs = cmem_q_valid_o && cmem_q_ready_i;
    assign mem_rsp_hs = cmem_p_valid_i && cmem_p_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            mem_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            if (do_pop)    wr_ptr <= wr_ptr + PTR_ONE;
            if (do_retire) rd_ptr <= rd_ptr + PTR_ONE;

            case ({do_pop, do_retire})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase

            case ({mem_req_hs, mem_rsp_hs})
                2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
                2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
                default: mem_cnt <= mem_cnt;
            endcase

            // Restarting at zero on every retire gives the next head a fresh delay.
            if (do_retire)
                wait_cnt <= '0;
            else if (head_valid && head_cls == CLS_INT && wait_cnt != WAIT_TGT)
                wait_cnt <= wait_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_pop) cls_q[wr_ptr] <= issue_cls;
    end

    assign inflight_cnt_o = occ;
    assign idle_o         = (occ == '0) && (mem_cnt == '0);

`ifdef FPU_SS_ISSUE_CTRL_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issued  <= '0;
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (do_pop)                  perf_issued  <= perf_issued + 32'd1;
            if (do_retire)               perf_retired <= perf_retired + 32'd1;
            if (pop_valid_i && !do_pop)  perf_stall   <= perf_stall + 32'd1;
        end
    end

    assign perf_issued_o  = perf_issued;
    assign perf_retired_o = perf_retired;
    assign perf_stall_o   = perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_ss_issue_ctrl.sv
`default_nettype none
// Bench for fpu_ss_issue_ctrl: issue-decode vector table, then multi-cycle
// sequences with a retire-order scoreboard and a fixed-latency FPU model.
module tb_fpu_ss_issue_ctrl;

    localparam int LAT = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic pop_valid_i, use_fpu_i, rd_is_fp_i, csr_instr_i, is_load_i, is_store_i;
    logic fpu_in_ready_i, fpu_out_valid_i, c_p_ready_i, cmem_q_ready_i, cmem_p_valid_i;
    logic pop_ready_o, fpu_in_valid_o, fpu_out_ready_o, fpr_we_o, c_p_valid_o;
    logic cmem_q_valid_o, cmem_q_mode_o, cmem_q_spec_o, cmem_q_endoftransaction_o;
    logic cmem_p_ready_o, idle_o;
    logic [2:0] inflight_cnt_o;
    acc_pkg::mem_req_type_e cmem_q_req_type_o;
`ifdef FPU_SS_ISSUE_CTRL_PERF_EN
    logic [31:0] perf_issued_o, perf_retired_o, perf_stall_o;
`endif

    fpu_ss_issue_ctrl #(
        .MAX_INFLIGHT(4), .MEM_MAX_OUTSTANDING(2), .INT_WB_DELAY(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pop_valid_i(pop_valid_i), .pop_ready_o(pop_ready_o),
        .use_fpu_i(use_fpu_i), .rd_is_fp_i(rd_is_fp_i), .csr_instr_i(csr_instr_i),
        .is_load_i(is_load_i), .is_store_i(is_store_i),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpr_we_o(fpr_we_o), .c_p_valid_o(c_p_valid_o), .c_p_ready_i(c_p_ready_i),
        .cmem_q_valid_o(cmem_q_valid_o), .cmem_q_ready_i(cmem_q_ready_i),
        .cmem_q_req_type_o(cmem_q_req_type_o), .cmem_q_mode_o(cmem_q_mode_o),
        .cmem_q_spec_o(cmem_q_spec_o), .cmem_q_endoftransaction_o(cmem_q_endoftransaction_o),
        .cmem_p_valid_i(cmem_p_valid_i), .cmem_p_ready_o(cmem_p_ready_o),
        .inflight_cnt_o(inflight_cnt_o),
`ifdef FPU_SS_ISSUE_CTRL_PERF_EN
        .perf_issued_o(perf_issued_o), .perf_retired_o(perf_retired_o),
        .perf_stall_o(perf_stall_o),
`endif
        .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int fpr_pulses = 0;
    int cur_kind = 0;
    bit mon_en = 1'b0;
    bit fpu_model_en = 1'b0;
    int sb[$];   // expected retire kinds: 0 = FPR write, 1 = C writeback, 2 = store ack
    int fq[$];   // FPU model: cycle at which each issued op's result becomes valid

    typedef struct {
        logic [7:0] stim;  // {pop_valid, use_fpu, rd_is_fp, csr, load, store, fpu_in_ready, cmem_q_ready}
        logic [3:0] expv;  // {pop_ready, fpu_in_valid, cmem_q_valid, req_type}
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr_inputs();
        pop_valid_i = 0; use_fpu_i = 0; rd_is_fp_i = 0; csr_instr_i = 0;
        is_load_i = 0; is_store_i = 0; fpu_in_ready_i = 0; fpu_out_valid_i = 0;
        c_p_ready_i = 0; cmem_q_ready_i = 0; cmem_p_valid_i = 0;
    endtask

    task automatic mon();
        int kind;
        bit ev;
        if (fpu_model_en) begin
            if (fpu_in_valid_o && fpu_in_ready_i) fq.push_back(cyc + LAT);
            if (fpu_out_valid_i && fpu_out_ready_o && fq.size() > 0) void'(fq.pop_front());
        end
        if (!mon_en) return;
        if (fpr_we_o) fpr_pulses++;
        if (pop_ready_o) sb.push_back(cur_kind);
        ev = 1'b1;
        kind = 0;
        if (fpr_we_o)                              kind = 0;
        else if (c_p_valid_o && c_p_ready_i)       kind = 1;
        else if (cmem_p_valid_i && cmem_p_ready_o) kind = 2;
        else                                       ev = 1'b0;
        if (ev) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got retire kind %0d, expected none", kind);
            end else begin
                chk("sb_order", kind, sb.pop_front());
            end
        end
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic adv();
        mon();
        @(posedge clk_i);
        #1;
        cyc++;
        if (fpu_model_en) fpu_out_valid_i = (fq.size() > 0) && (fq[0] <= cyc);
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        fq.delete();
        fpu_model_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            smp();
            if (idle_o) break;
            adv();
        end
        chk(name, idle_o, 1);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'b1000_0000, 4'b1000};  // INT issues unconditionally
        vt[1] = '{8'b1110_0010, 4'b1100};  // FPF, FPU ready
        vt[2] = '{8'b1100_0000, 4'b0100};  // FPI, FPU not ready
        vt[3] = '{8'b1000_1001, 4'b1010};  // LD, mem ready
        vt[4] = '{8'b1000_0100, 4'b0011};  // ST, mem not ready
        vt[5] = '{8'b1101_1011, 4'b1000};  // CSR overrides load and FPU
        vt[6] = '{8'b1000_1100, 4'b0010};  // load beats store
        vt[7] = '{8'b0110_0011, 4'b0000};  // nothing offered
        vt[8] = '{8'b1100_0101, 4'b1011};  // store beats FPU

        clr_inputs();
        rst_i = 1'b1;
        pop_valid_i = 1; fpu_in_ready_i = 1; is_store_i = 1; cmem_q_ready_i = 1;
        smp();
        chk("rst_pop_ready", pop_ready_o, 0);
        chk("rst_cmem_q_valid", cmem_q_valid_o, 0);
        chk("rst_req_type", cmem_q_req_type_o, acc_pkg::READ);
        chk("rst_idle", idle_o, 1);
        chk("rst_inflight", inflight_cnt_o, 0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            {pop_valid_i, use_fpu_i, rd_is_fp_i, csr_instr_i, is_load_i, is_store_i,
             fpu_in_ready_i, cmem_q_ready_i} = vt[i].stim;
            smp();
            chk($sformatf("v%0d_pop_ready", i), pop_ready_o, vt[i].expv[3]);
            chk($sformatf("v%0d_fpu_in_valid", i), fpu_in_valid_o, vt[i].expv[2]);
            chk($sformatf("v%0d_cmem_q_valid", i), cmem_q_valid_o, vt[i].expv[1]);
            chk($sformatf("v%0d_req_type", i), cmem_q_req_type_o, vt[i].expv[0]);
            adv();
            clr_inputs();
            smp();
            chk($sformatf("v%0d_inflight", i), inflight_cnt_o, vt[i].expv[3] ? 1 : 0);
            chk($sformatf("v%0d_idle", i), idle_o, vt[i].expv[3] ? 0 : 1);
            do_reset();
        end

        mon_en = 1'b1;

        // Back-to-back FPF with a fixed-latency FPU: fills the queue, 5th op waits.
        fpr_pulses = 0;
        fpu_model_en = 1'b1;
        c_p_ready_i = 1;
        pop_valid_i = 1; use_fpu_i = 1; rd_is_fp_i = 1; fpu_in_ready_i = 1; cur_kind = 0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("a_pop%0d", i), pop_ready_o, 1);
            adv();
        end
        smp();
        chk("a_full", inflight_cnt_o, 4);
        chk("a_stall_on_retire", pop_ready_o, 0);
        chk("a_first_we", fpr_we_o, 1);
        adv();
        smp();
        chk("a_resume", pop_ready_o, 1);
        adv();
        pop_valid_i = 0;
        wait_idle("a_idle", 40);
        chk("a_we_count", fpr_pulses, 5);
        do_reset();

        // FPF, FPI, INT with a late FPI result: INT must wait, then its delay.
        c_p_ready_i = 1; fpu_in_ready_i = 1;
        pop_valid_i = 1; use_fpu_i = 1; rd_is_fp_i = 1; cur_kind = 0;
        smp(); chk("b_pop_fpf", pop_ready_o, 1); adv();
        rd_is_fp_i = 0; cur_kind = 1;
        smp(); chk("b_pop_fpi", pop_ready_o, 1); adv();
        use_fpu_i = 0; cur_kind = 1;
        smp(); chk("b_pop_int", pop_ready_o, 1); adv();
        pop_valid_i = 0; fpu_out_valid_i = 1;
        smp(); chk("b_fpf_we", fpr_we_o, 1); adv();
        fpu_out_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            smp(); chk($sformatf("b_hold%0d", i), c_p_valid_o, 0); adv();
        end
        fpu_out_valid_i = 1;
        smp();
        chk("b_fpi_cp_valid", c_p_valid_o, 1);
        chk("b_fpi_out_ready", fpu_out_ready_o, 1);
        adv();
        fpu_out_valid_i = 0;
        smp(); chk("b_int_wait", c_p_valid_o, 0); adv();
        smp(); chk("b_int_cp_valid", c_p_valid_o, 1); adv();
        wait_idle("b_idle", 5);
        do_reset();

        // Three loads against a limit of two outstanding requests.
        pop_valid_i = 1; is_load_i = 1; cmem_q_ready_i = 1; cur_kind = 0;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk($sformatf("c_req%0d", i), cmem_q_valid_o, 1);
            chk($sformatf("c_pop%0d", i), pop_ready_o, 1);
            adv();
        end
        for (int i = 0; i < 2; i++) begin
            smp(); chk($sformatf("c_limit%0d", i), cmem_q_valid_o, 0); adv();
        end
        cmem_p_valid_i = 1;
        smp();
        chk("c_rsp_we", fpr_we_o, 1);
        chk("c_still_limited", cmem_q_valid_o, 0);
        adv();
        cmem_p_valid_i = 0;
        smp();
        chk("c_restore", cmem_q_valid_o, 1);
        chk("c_restore_pop", pop_ready_o, 1);
        adv();
        pop_valid_i = 0; is_load_i = 0; cmem_p_valid_i = 1;
        for (int i = 0; i < 2; i++) begin
            smp(); chk($sformatf("c_rsp_we_tail%0d", i), fpr_we_o, 1); adv();
        end
        cmem_p_valid_i = 0;
        wait_idle("c_idle", 5);
        do_reset();

        // Store at head, FPU result arrives first and must stall.
        pop_valid_i = 1; is_store_i = 1; cmem_q_ready_i = 1; cur_kind = 2;
        smp(); chk("d_st_pop", pop_ready_o, 1); adv();
        is_store_i = 0; use_fpu_i = 1; rd_is_fp_i = 1; fpu_in_ready_i = 1; cur_kind = 0;
        smp(); chk("d_fpf_pop", pop_ready_o, 1); adv();
        pop_valid_i = 0; fpu_out_valid_i = 1;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk($sformatf("d_blocked%0d", i), fpu_out_ready_o, 0);
            chk($sformatf("d_no_we%0d", i), fpr_we_o, 0);
            chk($sformatf("d_occ%0d", i), inflight_cnt_o, 2);
            adv();
        end
        cmem_p_valid_i = 1;
        smp();
        chk("d_st_rsp_ready", cmem_p_ready_o, 1);
        chk("d_st_rsp_no_we", fpr_we_o, 0);
        chk("d_st_rsp_fpu_blocked", fpu_out_ready_o, 0);
        adv();
        cmem_p_valid_i = 0;
        smp();
        chk("d_fpf_ready", fpu_out_ready_o, 1);
        chk("d_fpf_we", fpr_we_o, 1);
        adv();
        fpu_out_valid_i = 0;
        wait_idle("d_idle", 5);
        do_reset();

        // FPI writeback under core backpressure.
        pop_valid_i = 1; use_fpu_i = 1; fpu_in_ready_i = 1; cur_kind = 1;
        smp(); chk("e_pop", pop_ready_o, 1); adv();
        pop_valid_i = 0; fpu_out_valid_i = 1; c_p_ready_i = 0;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk($sformatf("e_cp_valid%0d", i), c_p_valid_o, 1);
            chk($sformatf("e_out_ready%0d", i), fpu_out_ready_o, 0);
            chk($sformatf("e_occ%0d", i), inflight_cnt_o, 1);
            adv();
        end
        c_p_ready_i = 1;
        smp(); chk("e_release", fpu_out_ready_o, 1); adv();
        fpu_out_valid_i = 0;
        wait_idle("e_idle", 5);
        do_reset();

        // Asynchronous reset with three entries and one memory request in flight.
        c_p_ready_i = 1; fpu_in_ready_i = 1; cmem_q_ready_i = 1;
        pop_valid_i = 1; use_fpu_i = 1; rd_is_fp_i = 1; cur_kind = 0;
        smp(); chk("f_pop_fpf", pop_ready_o, 1); adv();
        use_fpu_i = 0; rd_is_fp_i = 0; is_load_i = 1;
        smp(); chk("f_pop_ld", pop_ready_o, 1); adv();
        is_load_i = 0; use_fpu_i = 1; cur_kind = 1;
        smp(); chk("f_pop_fpi", pop_ready_o, 1); adv();
        rd_is_fp_i = 1; fpu_out_valid_i = 1;
        smp();
        chk("f_pre_occ", inflight_cnt_o, 3);
        chk("f_pre_fpu_in_valid", fpu_in_valid_o, 1);
        chk("f_pre_out_ready", fpu_out_ready_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("f_pop_ready", pop_ready_o, 0);
        chk("f_fpu_in_valid", fpu_in_valid_o, 0);
        chk("f_fpu_out_ready", fpu_out_ready_o, 0);
        chk("f_fpr_we", fpr_we_o, 0);
        chk("f_c_p_valid", c_p_valid_o, 0);
        chk("f_cmem_q_valid", cmem_q_valid_o, 0);
        chk("f_cmem_p_ready", cmem_p_ready_o, 0);
        chk("f_idle", idle_o, 1);
        chk("f_inflight", inflight_cnt_o, 0);
`ifdef FPU_SS_ISSUE_CTRL_PERF_EN
        chk("f_perf_issued", perf_issued_o, 0);
        chk("f_perf_retired", perf_retired_o, 0);
        chk("f_perf_stall", perf_stall_o, 0);
`endif
        mon_en = 1'b0;
        clr_inputs();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        fq.delete();
        smp();
        chk("f_post_idle", idle_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
